axis_bram_writer: RTL and testbench

AXIS_BRAM_WRITER -- requirements
Module: axis_bram_writer

---
 rtl/axis_bram_writer.sv | 119 +++++++++++
 tb/tb_axis_bram_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_writer.sv
// AXI4-Stream to BRAM port-A writer: writes each accepted beat at a running
// address up to a programmable limit, then stops (FULL) or wraps (CONTINUOUS).
module axis_bram_writer #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BRAM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_ADDR_WIDTH  = 10,
  parameter string       CONTINUOUS       = "FALSE",
  parameter string       SYNC_TLAST       = "FALSE"
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_data,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_data,
  output logic                         sts_full,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         a_bram_clk,
  output logic                         a_bram_rst,
  output logic                         a_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] a_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]   a_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   a_bram_wdata
);

  localparam int unsigned WE_WIDTH = BRAM_DATA_WIDTH / 8;
  localparam bit          CONT_EN  = (CONTINUOUS == "TRUE");
  localparam bit          SYNC_EN  = (SYNC_TLAST == "TRUE");

  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [BRAM_ADDR_WIDTH-1:0] limit_q, limit_d;
  logic                       wr_beat_c;
  logic                       tready_c;

  // State, address and registered limit; synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      limit_q <= limit_d;
    end
  end

  // Next-state, address update and beat qualification.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    limit_d   = cfg_data;
    wr_beat_c = 1'b0;
    tready_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = SYNC_EN ? ST_ALIGN : ST_FILL;
      end

      // Drop input until the end of a frame so the first write starts a frame.
      ST_ALIGN: begin
        tready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_FILL;
          addr_d  = '0;
        end
      end

      ST_FILL: begin
        tready_c  = 1'b1;
        wr_beat_c = s_axis_tvalid;
        if (s_axis_tvalid) begin
          if (addr_q < limit_q) begin
            addr_d = addr_q + ADDR_ONE;
          end else if (CONT_EN) begin
            addr_d = '0;
          end else begin
            state_d = ST_FULL;
          end
        end
      end

      // A raised limit extends the buffer past the last written word.
      ST_FULL: begin
        if (limit_q > addr_q) begin
          state_d = ST_FILL;
          addr_d  = addr_q + ADDR_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Zero-latency BRAM port and stream handshake, forced idle during reset.
  assign s_axis_tready = aresetn & tready_c;
  assign a_bram_en     = aresetn & wr_beat_c;
  assign a_bram_we     = {WE_WIDTH{a_bram_en}};
  assign a_bram_addr   = addr_q;
  assign a_bram_wdata  = s_axis_tdata[BRAM_DATA_WIDTH-1:0];
  assign a_bram_clk    = aclk;
  assign a_bram_rst    = ~aresetn;

  assign sts_data = addr_q;
  assign sts_full = (state_q == ST_FULL);

endmodule

// File: tb/tb_axis_bram_writer.sv
// Directed bench: three writer instances (stop, continuous, tlast-sync) share stimulus.
module tb_axis_bram_writer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [9:0]  cfg_data = '0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;

  logic [9:0]  a_sts, c_sts, s_sts;
  logic        a_full, c_full, s_full;
  logic        a_tready, c_tready, s_tready;
  logic        a_bclk, c_bclk, s_bclk;
  logic        a_brst, c_brst, s_brst;
  logic        a_en, c_en, s_en;
  logic [3:0]  a_we, c_we, s_we;
  logic [9:0]  a_addr, c_addr, s_addr;
  logic [31:0] a_wdata, c_wdata, s_wdata;

  int n_checks = 0;
  int n_fail = 0;
  int we_bad = 0;
  int en_in_rst = 0;

  logic [9:0]  qa_addr[$];
  logic [31:0] qa_data[$];
  logic [9:0]  qc_addr[$];
  logic [31:0] qc_data[$];
  logic [9:0]  qs_addr[$];
  logic [31:0] qs_data[$];

  always #5 clk = ~clk;

  axis_bram_writer #(.CONTINUOUS("FALSE"), .SYNC_TLAST("FALSE")) u_a (
    .aclk(clk), .aresetn(aresetn), .cfg_data(cfg_data), .sts_data(a_sts), .sts_full(a_full),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(a_tready),
    .a_bram_clk(a_bclk), .a_bram_rst(a_brst), .a_bram_en(a_en), .a_bram_we(a_we),
    .a_bram_addr(a_addr), .a_bram_wdata(a_wdata));

  axis_bram_writer #(.CONTINUOUS("TRUE"), .SYNC_TLAST("FALSE")) u_c (
    .aclk(clk), .aresetn(aresetn), .cfg_data(cfg_data), .sts_data(c_sts), .sts_full(c_full),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(c_tready),
    .a_bram_clk(c_bclk), .a_bram_rst(c_brst), .a_bram_en(c_en), .a_bram_we(c_we),
    .a_bram_addr(c_addr), .a_bram_wdata(c_wdata));

  axis_bram_writer #(.CONTINUOUS("FALSE"), .SYNC_TLAST("TRUE")) u_s (
    .aclk(clk), .aresetn(aresetn), .cfg_data(cfg_data), .sts_data(s_sts), .sts_full(s_full),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(s_tready),
    .a_bram_clk(s_bclk), .a_bram_rst(s_brst), .a_bram_en(s_en), .a_bram_we(s_we),
    .a_bram_addr(s_addr), .a_bram_wdata(s_wdata));

  // Write logger: samples the combinational BRAM port mid-cycle.
  always @(negedge clk) begin
    if (a_en) begin qa_addr.push_back(a_addr); qa_data.push_back(a_wdata); end
    if (c_en) begin qc_addr.push_back(c_addr); qc_data.push_back(c_wdata); end
    if (s_en) begin qs_addr.push_back(s_addr); qs_data.push_back(s_wdata); end
    if ((a_en && a_we != 4'hF) || (c_en && c_we != 4'hF) || (s_en && s_we != 4'hF)) we_bad++;
    if ((!a_en && a_we != 4'h0) || (!c_en && c_we != 4'h0) || (!s_en && s_we != 4'h0)) we_bad++;
    if (!aresetn && (a_en || c_en || s_en)) en_in_rst++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle and stop mid-cycle so outputs can be checked.
  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    tvalid = v;
    tdata  = d;
    tlast  = l;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic l);
    drive(v, d, l);
    tick();
  endtask

  task automatic clear_logs();
    qa_addr.delete(); qa_data.delete();
    qc_addr.delete(); qc_data.delete();
    qs_addr.delete(); qs_data.delete();
  endtask

  // Two reset cycles, then release just after an edge; the next cycle is IDLE.
  task automatic do_reset(input logic [9:0] cfg);
    cfg_data = cfg;
    aresetn  = 1'b0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    clear_logs();
  endtask

  initial begin
    int sent;
    int ncyc;

    // Reset state, observed after edges with aresetn low.
    cfg_data = 10'd3;
    tvalid = 1'b1;
    tdata = 32'hFF;
    tick();
    drive(1'b1, 32'hFF, 1'b0);
    check("rst_sts", a_sts, 0);
    check("rst_full", a_full, 0);
    check("rst_tready", a_tready, 0);
    check("rst_en", a_en, 0);
    check("rst_bram_rst", a_brst, 1);
    tick();
    aresetn = 1'b1;
    clear_logs();

    // Stop mode, limit 3, six beats.
    cyc(1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'hA0 + i, 1'b0);
    drive(1'b0, 0, 1'b0);
    check("s1_nwr", qa_addr.size(), 4);
    for (int i = 0; i < 4 && i < qa_addr.size(); i++) begin
      check($sformatf("s1_addr%0d", i), qa_addr[i], i);
      check($sformatf("s1_data%0d", i), qa_data[i], 32'hA0 + i);
    end
    check("s1_tready", a_tready, 0);
    check("s1_full", a_full, 1);
    check("s1_sts", a_sts, 3);
    tick();

    // Raise the limit to 5: buffer extends to addresses 4 and 5.
    clear_logs();
    cfg_data = 10'd5;
    cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hB0 + i, 1'b0);
    drive(1'b0, 0, 1'b0);
    check("s2_nwr", qa_addr.size(), 2);
    if (qa_addr.size() >= 2) begin
      check("s2_addr0", qa_addr[0], 4);
      check("s2_data0", qa_data[0], 32'hB0);
      check("s2_addr1", qa_addr[1], 5);
      check("s2_data1", qa_data[1], 32'hB1);
    end
    check("s2_full", a_full, 1);
    check("s2_sts", a_sts, 5);
    tick();

    // Continuous mode, limit 2, seven beats.
    do_reset(10'd2);
    cyc(1'b0, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'hC0 + i, 1'b0);
      check($sformatf("s3_full%0d", i), c_full, 0);
      tick();
    end
    drive(1'b0, 0, 1'b0);
    check("s3_nwr", qc_addr.size(), 7);
    for (int i = 0; i < 7 && i < qc_addr.size(); i++) begin
      check($sformatf("s3_addr%0d", i), qc_addr[i], i % 3);
      check($sformatf("s3_data%0d", i), qc_data[i], 32'hC0 + i);
    end
    check("s3_sts", c_sts, 1);
    check("s3_full", c_full, 0);
    tick();

    // Tlast alignment: d0, d1(last) dropped; d2, d3 written at 0, 1.
    do_reset(10'd7);
    drive(1'b0, 0, 1'b0);
    check("s4_idle_tready", s_tready, 0);
    tick();
    drive(1'b1, 32'hD0, 1'b0);
    check("s4_align_tready", s_tready, 1);
    check("s4_align_en0", s_en, 0);
    tick();
    drive(1'b1, 32'hD1, 1'b1);
    check("s4_align_en1", s_en, 0);
    tick();
    cyc(1'b1, 32'hD2, 1'b0);
    cyc(1'b1, 32'hD3, 1'b1);
    drive(1'b0, 0, 1'b0);
    check("s4_nwr", qs_addr.size(), 2);
    if (qs_addr.size() >= 2) begin
      check("s4_addr0", qs_addr[0], 0);
      check("s4_data0", qs_data[0], 32'hD2);
      check("s4_addr1", qs_addr[1], 1);
      check("s4_data1", qs_data[1], 32'hD3);
    end
    check("s4_sts", s_sts, 2);
    tick();

    // Random tvalid gaps, limit 15: 20 beats offered, first 16 written.
    do_reset(10'd15);
    cyc(1'b0, 0, 1'b0);
    sent = 0;
    ncyc = 0;
    while (sent < 20 && ncyc < 400) begin
      if ($urandom_range(0, 1) == 1) begin
        cyc(1'b1, 32'h5000 + sent, 1'b0);
        sent++;
      end else begin
        cyc(1'b0, 32'hDEAD, 1'b0);
      end
      ncyc++;
    end
    check("s5_sent", sent, 20);
    drive(1'b0, 0, 1'b0);
    check("s5_nwr", qa_addr.size(), 16);
    for (int i = 0; i < 16 && i < qa_addr.size(); i++) begin
      check($sformatf("s5_addr%0d", i), qa_addr[i], i);
      check($sformatf("s5_data%0d", i), qa_data[i], 32'h5000 + i);
    end
    check("s5_full", a_full, 1);
    check("s5_sts", a_sts, 15);
    tick();

    // Mid-frame reset pulse after writing address 2.
    do_reset(10'd7);
    cyc(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hE0 + i, 1'b0);
    aresetn = 1'b0;
    drive(1'b1, 32'hE3, 1'b0);
    check("s6_rst_en", a_en, 0);
    check("s6_rst_tready", a_tready, 0);
    tick();
    aresetn = 1'b1;
    drive(1'b1, 32'hE4, 1'b0);
    check("s6_idle_en", a_en, 0);
    check("s6_idle_tready", a_tready, 0);
    check("s6_idle_sts", a_sts, 0);
    tick();
    drive(1'b1, 32'hE5, 1'b0);
    check("s6_post_en", a_en, 1);
    check("s6_post_addr", a_addr, 0);
    tick();
    drive(1'b0, 0, 1'b0);
    check("s6_nwr", qa_addr.size(), 4);
    if (qa_addr.size() >= 4) begin
      check("s6_addr2", qa_addr[2], 2);
      check("s6_data2", qa_data[2], 32'hE2);
      check("s6_addr3", qa_addr[3], 0);
      check("s6_data3", qa_data[3], 32'hE5);
    end
    check("s6_sts", a_sts, 1);
    tick();

    check("we_strobes", we_bad, 0);
    check("en_in_reset", en_in_rst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
